// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    // Rounded-to-nearest number of clk cycles per line bit.
    function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
        return (clock_rate + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic q_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p0 <= 1'b1;
            q    <= 1'b1;
        end else begin
            q_p0 <= d;
            q    <= q_p0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with mid-bit sampling, framing check and glitch rejection.
// Optional even parity is compiled in with `define UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_RATE = 100_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CPB   = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  valid_nxt, ferr_nxt;
    logic                  rx_s, rx_d;
    logic                  bit_end;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign bit_end = (cnt == CNT_W'(CPB - 1));

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_nxt, perr_nxt, par_bad;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign par_bad = ^{shreg, par_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_nxt;
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            rx_d      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
            rx_d      <= rx_s;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        data_nxt    = data;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt     = par_bit;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    state_nxt   = START;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                end
            end
            // Re-check the line at mid start bit so short glitches are dropped.
            START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[DATA_WIDTH-1:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    par_nxt   = rx_s;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                    perr_nxt = par_bad;
`endif
                    if (rx_s) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (!par_bad) begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
                        end
`else
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
`endif
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            // Line held low (break): wait for idle before hunting for a start edge.
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model with an event queue and a per-cycle compare.
module tb_uart_rx;

    localparam int CPB = 10;
    localparam int DW  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NOM = (1 + DW + PB) * CPB + CPB / 2 + 2;

    typedef struct {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] d;
        int         stamp;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err;

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   n_valid = 0;
    int   n_ferr = 0;
    int   n_perr = 0;
    logic [7:0] model_data = 8'h00;
    ev_t  exp_q[$];
    logic pv = 1'b0, pf = 1'b0, pp = 1'b0;

    uart_rx #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (9600),
        .CLOCK_RATE (100_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Compare process: every pulse must match the next frame the bench sent.
    always @(negedge clk) begin
        ev_t e;
        int  d;
        if (!rst_n) begin
            model_data = 8'h00;
            check("reset_pulses", {29'd0, valid, frame_err, parity_err}, 32'd0);
        end else if (valid || frame_err || parity_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, valid, frame_err, parity_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {29'd0, valid, frame_err, parity_err}, {29'd0, e.v, e.fe, e.pe});
                d = cycle - e.stamp;
                check("pulse_latency_in_window", {31'd0, (d >= NOM - 3) && (d <= NOM + 3)}, 32'd1);
                if (e.v) model_data = e.d;
            end
            if (valid) n_valid++;
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
        end
        check("data_held", {24'd0, data}, {24'd0, model_data});
        check("single_cycle_pulse", {31'd0, (valid && pv) || (frame_err && pf) || (parity_err && pp)}, 32'd0);
`ifndef UART_RX_PARITY_EN
        check("parity_err_tied", {31'd0, parity_err}, 32'd0);
`endif
        pv = valid;
        pf = frame_err;
        pp = parity_err;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(CPB);
    endtask

    // pmode: 0/1 force that parity bit, 2 send the correct even parity.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pmode);
        ev_t  e;
        logic pbit;
        logic pbad;
        pbit    = (pmode == 2) ? ^b : pmode[0];
        pbad    = (PB == 1) && (pbit != ^b);
        e.v     = stop && !pbad;
        e.fe    = !stop;
        e.pe    = pbad;
        e.d     = b;
        e.stamp = cycle;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop);
    endtask

    initial begin
        logic [7:0] msg [13];
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20};

        rst_n = 1'b0;
        rx    = 1'b1;
        idle(3);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(2 * CPB);

        send_frame(8'h48, 1'b1, 2);
        idle(5);
        check("H_data", {24'd0, data}, 32'h48);
        check("H_valid_count", n_valid, 1);
        check("H_no_frame_err", n_ferr, 0);

        foreach (msg[i]) send_frame(msg[i], 1'b1, 2);
        idle(5);
        check("hello_valid_count", n_valid, 14);
        check("hello_last_data", {24'd0, data}, 32'h20);

        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(2 * CPB);
        check("glitch_no_valid", n_valid, 14);
        send_frame(8'h55, 1'b1, 2);
        idle(5);
        check("after_glitch_data", {24'd0, data}, 32'h55);

        send_frame(8'hA5, 1'b0, 2);
        check("stop_low_frame_err", n_ferr, 1);
        check("stop_low_data_kept", {24'd0, data}, 32'h55);
        check("stop_low_no_valid", n_valid, 15);
        idle(CPB);
        rx = 1'b1;
        idle(2 * CPB);
        send_frame(8'h3C, 1'b1, 2);
        send_frame(8'hFF, 1'b1, 2);
        send_frame(8'h00, 1'b1, 2);
        idle(5);
        check("boundary_data_00", {24'd0, data}, 32'h00);
        check("after_break_valid_count", n_valid, 18);

        send_frame(8'h81, 1'b1, 2);
        idle(5);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b0;
        idle(3);
        check("midframe_rst_data", {24'd0, data}, 32'h00);
        rst_n = 1'b1;
        idle(2 * CPB);
        check("midframe_rst_no_valid", n_valid, 19);
        send_frame(8'h0F, 1'b1, 2);
        idle(5);
        check("after_rst_data", {24'd0, data}, 32'h0F);
        check("after_rst_valid_count", n_valid, 20);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 0);
        idle(5);
        check("parity_bad_err_count", n_perr, 1);
        check("parity_bad_data_kept", {24'd0, data}, 32'h0F);
        send_frame(8'h07, 1'b1, 1);
        idle(5);
        check("parity_ok_data", {24'd0, data}, 32'h07);
        check("parity_ok_valid_count", n_valid, 21);
`endif

        idle(CPB);
        check("all_frames_seen", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        total++;
        bad++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have parameter BAUD_RATE, default 9600: line bit rate in bits/s.
REQ-003 SHALL have parameter CLOCK_RATE, default 100_000: clk frequency in Hz.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port data, output, DATA_WIDTH bits: last correctly framed word received.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse when data has just been updated.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch (see Configuration).

Function
REQ-011 SHALL compute CLKS_PER_BIT = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE, integer, which is 10 for the defaults.
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-014 In IDLE, SHALL go to START on a synchronized high-to-low transition and clear the bit counter.
REQ-015 In START, after CLKS_PER_BIT/2 clocks, SHALL go to DATA if rx is low, else return to IDLE (glitch rejection).
REQ-016 In DATA, SHALL sample rx every CLKS_PER_BIT clocks, LSB first, for exactly DATA_WIDTH samples into a shift register.
REQ-017 After the last data bit, SHALL go to PARITY if parity is compiled in, else to STOP.
REQ-018 In STOP, one CLKS_PER_BIT after the last sample: if rx is high, SHALL load data, pulse valid and go to IDLE.
REQ-019 In STOP, if rx is low, SHALL pulse frame_err, leave data unchanged and go to WAIT_IDLE.
REQ-020 In WAIT_IDLE, SHALL remain until rx is high, then go to IDLE (break/line-low handling).
REQ-021 SHALL hold data stable between updates; valid, frame_err and parity_err SHALL never be high for more than one consecutive cycle.
REQ-022 A new start edge arriving in the cycle that STOP returns to IDLE SHALL be accepted, so back-to-back frames with one stop bit are received with no loss.
REQ-023 SHALL tolerate a baud mismatch up to ±4% at mid-bit sampling.

Reset
REQ-024 While rst_n is low, SHALL force state IDLE, counters 0, both synchronizer flops 1, data 0, valid 0, frame_err 0 and parity_err 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valid pulse; reception SHALL resume at the next start edge after rst_n deasserts.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, SHALL expect one even-parity bit after the data bits, sampled like a data bit.
REQ-027 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse parity_err together with the stop-bit decision and SHALL suppress valid and the data update.
REQ-028 Without UART_RX_PARITY_EN, SHALL skip the PARITY state and tie parity_err to 0.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum type and a function clks_per_bit(clock_rate, baud_rate) implementing REQ-011.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named uart_sync with clk, rst_n, d and q ports and a reset value of 1.

Verification (defaults: 10 clocks per bit, 8N1 frames unless stated)
REQ-031 Send 0x48 ('H') -> data=0x48 and one valid pulse about 9.5 bit times plus 2 clocks after the start edge; frame_err stays 0.
REQ-032 Send the 13 bytes of "Hello World! " back to back -> 13 valid pulses with data 0x48,0x65,0x6C,0x6C,0x6F,0x20,0x57,0x6F,0x72,0x6C,0x64,0x21,0x20 in order.
REQ-033 Drive rx low for 3 clocks then high -> no valid, FSM back in IDLE, and a following 0x55 frame is received correctly.
REQ-034 Send 0xA5 with the stop bit low -> one frame_err pulse, no valid, data keeps its prior value; after rx returns high, 0x3C is received.
REQ-035 Assert rst_n low during data bit 4, then send 0x0F -> data=0x00 after reset, then data=0x0F with exactly one valid pulse.
REQ-036 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> one parity_err pulse, no valid; with parity bit 1 -> data=0x07 and valid.
